ioctl_rom_writer: RTL and testbench

- Consumes the SPI-side download stream (ioctl_download / ioctl_wr toggle / ioctl_addr / ioctl_dout) and turns each 16-bit word into a write request toward the SDRAM controller port that holds the HuCard ROM image.
- Decouples the toggle-strobe source from a memory port with variable latency using a small FIFO.
- Tracks the loaded ROM size and signals load completion to the core's reset/mapper logic.

---
 rtl/ioctl_rom_writer.sv | 203 ++++++++++++++++++++
 tb/tb_ioctl_rom_writer.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_writer.sv
// ioctl_rom_writer
//   Turns the toggle-strobed ioctl download stream into write requests for the
//   SDRAM port that holds the HuCard ROM image. A small FIFO decouples the
//   strobe source from the variable-latency memory port. The block also tracks
//   the loaded ROM size and pulses load_done when a load has fully drained.
//
// Ports
//   clk_sys, reset          system clock, synchronous active-high reset
//   ioctl_download/index    transfer active flag and menu index of the file
//   ioctl_wr                toggle strobe, one level change per word
//   ioctl_addr/dout         even byte address and 16-bit word data
//   mem_req/addr/din        write request, held until mem_ack
//   mem_ack                 one-cycle accept pulse from the memory port
//   load_busy, load_done    load in progress / one-cycle completion pulse
//   rom_size                highest written byte address + 2 of the last load
//   overflow                sticky, a word was dropped on a full FIFO
//
// Build option
//   IOCTL_HDR_SKIP_EN       when defined, ioctl_index[7] flags a 512-byte
//                           header that is stripped from the image; the index
//                           compare then uses bits [6:0] only.

module ioctl_rom_writer #(
    parameter logic [7:0]  ROM_INDEX  = 8'h01,
    parameter logic [24:0] BASE_ADDR  = 25'h0000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic        mem_ack,
    output logic        load_busy,
    output logic        load_done,
    output logic [24:0] rom_size,
    output logic        overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state;
    logic          wr_d;
    logic          dl_d;
    logic          rise_pend;

    // Capture stage: one word sampled the cycle its strobe edge is seen.
    logic          cap_valid;
    logic [24:0]   cap_addr;
    logic [15:0]   cap_data;

    logic [24:0]   fifo_addr [FIFO_DEPTH];
    logic [15:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          idx_match;
    logic          skip_hdr;
    logic [24:0]   adj_addr;
    logic          wr_ev;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          dl_rise;
    logic          dl_fall;
    logic          start_load;
    logic          drain_done;
    logic [24:0]   push_end;
    logic [24:0]   head_addr;

    always_comb begin
`ifdef IOCTL_HDR_SKIP_EN
        idx_match = (ioctl_index[6:0] == ROM_INDEX[6:0]);
        skip_hdr  = ioctl_index[7] && (ioctl_addr < 25'd512);
        adj_addr  = ioctl_index[7] ? (ioctl_addr - 25'd512) : ioctl_addr;
`else
        idx_match = (ioctl_index == ROM_INDEX);
        skip_hdr  = 1'b0;
        adj_addr  = ioctl_addr;
`endif
    end

    assign wr_ev = (ioctl_wr != wr_d) && ioctl_download && idx_match &&
                   (state == ST_LOAD) && !skip_hdr;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    // A request slot opens only when nothing is outstanding.
    assign pop        = !mem_req && !fifo_empty;
    // A full FIFO still takes the word if the head leaves in the same cycle.
    assign push       = cap_valid && (!fifo_full || pop);

    assign dl_rise    = ioctl_download && !dl_d;
    assign dl_fall    = !ioctl_download && dl_d;
    assign start_load = (state == ST_IDLE) && (dl_rise || rise_pend);
    assign drain_done = (state == ST_DRAIN) && fifo_empty && !mem_req && !cap_valid;
    assign push_end   = cap_addr + 25'd2;
    assign head_addr  = BASE_ADDR + fifo_addr[rd_ptr];

    // Storage needs no reset; validity is carried by the pointers and count.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cap_addr;
            fifo_data[wr_ptr] <= cap_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_d      <= ioctl_wr;
            dl_d      <= 1'b0;
            rise_pend <= 1'b0;
            cap_valid <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            rom_size  <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_d      <= ioctl_wr;
            dl_d      <= ioctl_download;
            load_done <= 1'b0;
            cap_valid <= wr_ev;
            if (wr_ev) begin
                cap_addr <= adj_addr;
                cap_data <= ioctl_dout;
            end

            if (pop) begin
                mem_req  <= 1'b1;
                mem_addr <= head_addr & ~25'd1;
                mem_din  <= fifo_data[rd_ptr];
            end else if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
            end

            if (start_load) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                rom_size  <= '0;
                overflow  <= 1'b0;
                load_busy <= 1'b1;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (push_end > rom_size) rom_size <= push_end;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (cap_valid && !push) overflow <= 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (start_load) begin
                        state     <= ST_LOAD;
                        rise_pend <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (dl_fall) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Remember a new download that starts before the drain ends.
                    if (dl_rise) rise_pend <= 1'b1;
                    else if (dl_fall) rise_pend <= 1'b0;
                    if (drain_done) begin
                        load_done <= 1'b1;
                        load_busy <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_rom_writer.sv
module tb_ioctl_rom_writer;

    localparam logic [24:0] BASE = 25'h0100000;
    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h01;
    logic        ioctl_wr = 1'b1;
    logic [24:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        mem_req;
    logic [24:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_ack;
    logic        load_busy;
    logic        load_done;
    logic [24:0] rom_size;
    logic        overflow;

    always #5 clk_sys = ~clk_sys;

    ioctl_rom_writer #(
        .ROM_INDEX  (8'h01),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_ack        (mem_ack),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .rom_size       (rom_size),
        .overflow       (overflow)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Memory-side responder: acks ack_lat cycles into each request.
    int ack_lat = 0;
    bit ack_en = 1'b1;
    bit ack_force = 1'b0;
    int ack_wait = 0;

    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (ack_force) begin
                mem_ack = 1'b1;
            end else if (ack_en && mem_req) begin
                if (ack_wait >= ack_lat) begin
                    mem_ack = 1'b1;
                    ack_wait = 0;
                end else begin
                    mem_ack = 1'b0;
                    ack_wait++;
                end
            end else begin
                mem_ack = 1'b0;
                ack_wait = 0;
            end
        end
    end

    // Observation: accepted writes, load_done pulses, request stability.
    logic [24:0] got_addr[$];
    logic [15:0] got_data[$];
    int          got_t[$];
    int          done_cnt = 0;
    int          busy_bad = 0;
    int          unstable = 0;
    int          req_cycles = 0;
    logic [24:0] done_size = '0;
    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic [24:0] p_addr = '0;
    logic [15:0] p_din = '0;

    always @(negedge clk_sys) begin
        if (mem_req && mem_ack) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_din);
            got_t.push_back(cyc);
        end
        if (mem_req && p_req && !p_ack && (mem_addr !== p_addr || mem_din !== p_din))
            unstable <= unstable + 1;
        if (mem_req) req_cycles <= req_cycles + 1;
        if (load_done) begin
            done_cnt  <= done_cnt + 1;
            done_size <= rom_size;
            if (load_busy !== 1'b0) busy_bad <= busy_bad + 1;
        end
        p_req  <= mem_req;
        p_ack  <= mem_ack;
        p_addr <= mem_addr;
        p_din  <= mem_din;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic clear_obs();
        got_addr.delete();
        got_data.delete();
        got_t.delete();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        step(2);
    endtask

    task automatic send_word(input logic [7:0] idx, input logic [24:0] a,
                             input logic [15:0] d, input int gap);
        ioctl_index = idx;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = ~ioctl_wr;
        step(gap);
    endtask

    task automatic end_and_wait(output bit timed_out);
        int d0;
        d0 = done_cnt;
        ioctl_download = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_download = 1'b0;
        step(3);
        reset = 1'b0;
        step(5);
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_mem_req got=%b exp=0", mem_req);
        end
        total++;
        if ({mem_addr, mem_din} !== 41'd0) begin
            bad++;
            $display("FAIL reset_addr_data got=%h/%h exp=0/0", mem_addr, mem_din);
        end
        total++;
        if ({load_busy, load_done, overflow} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000", {load_busy, load_done, overflow});
        end
        total++;
        if (rom_size !== 25'd0) begin
            bad++;
            $display("FAIL reset_rom_size got=%h exp=0", rom_size);
        end
        total++;
        if (req_cycles !== 0) begin
            bad++;
            $display("FAIL reset_no_req got=%0d exp=0", req_cycles);
        end
    endtask

    task automatic test_basic();
        bit to;
        int d0, b0, u0;
        clear_obs();
        d0 = done_cnt; b0 = busy_bad; u0 = unstable;
        ack_en = 1'b1; ack_lat = 3;
        start_dl(8'h01);
        for (int i = 0; i < 4; i++) send_word(8'h01, 25'(2 * i), 16'(16'h1111 * (i + 1)), 8);
        end_and_wait(to);
        step(5);
        total++;
        if (to) begin
            bad++;
            $display("FAIL basic_done_timeout got=none exp=load_done");
        end
        total++;
        if (got_addr.size() !== 4) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=4", got_addr.size());
        end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== BASE + 25'(2 * i) || got_data[i] !== 16'(16'h1111 * (i + 1))) begin
                bad++;
                $display("FAIL basic_word%0d got=%h/%h exp=%h/%h", i, got_addr[i], got_data[i],
                         BASE + 25'(2 * i), 16'(16'h1111 * (i + 1)));
            end
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0);
        end
        total++;
        if (done_size !== 25'd8 || rom_size !== 25'd8) begin
            bad++;
            $display("FAIL basic_rom_size got=%h/%h exp=8", done_size, rom_size);
        end
        total++;
        if (busy_bad !== b0 || load_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_fall got=%0d/%b exp=%0d/0", busy_bad, load_busy, b0);
        end
        total++;
        if (unstable !== u0) begin
            bad++;
            $display("FAIL basic_req_stable got=%0d exp=%0d", unstable, u0);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            logic [24:0] ea[$];
            logic [15:0] ed[$];
            logic [24:0] msize;
            logic [24:0] a, e;
            logic [15:0] d;
            logic [7:0]  idx;
            int n, lat;
            bit to;
            clear_obs();
            msize = '0;
            lat = int'($urandom_range(0, 4));
            ack_lat = lat;
            n = int'($urandom_range(6, 14));
            start_dl(8'h01);
            for (int i = 0; i < n; i++) begin
                idx = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h01;
                a = {$urandom_range(0, 32'hFFFFFF), 1'b0};
                d = 16'($urandom);
                if (idx == 8'h01) begin
                    ea.push_back(BASE + a);
                    ed.push_back(d);
                    e = a + 25'd2;
                    if (e > msize) msize = e;
                end
                send_word(idx, a, d, lat + 4);
            end
            end_and_wait(to);
            total++;
            if (to || got_addr.size() !== ea.size()) begin
                bad++;
                $display("FAIL rand%0d_count got=%0d exp=%0d timeout=%b", r, got_addr.size(),
                         ea.size(), to);
            end
            for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
                total++;
                if (got_addr[i] !== ea[i] || got_data[i] !== ed[i]) begin
                    bad++;
                    $display("FAIL rand%0d_word%0d got=%h/%h exp=%h/%h", r, i, got_addr[i],
                             got_data[i], ea[i], ed[i]);
                end
            end
            total++;
            if (done_size !== msize || overflow !== 1'b0) begin
                bad++;
                $display("FAIL rand%0d_size got=%h ovf=%b exp=%h ovf=0", r, done_size, overflow,
                         msize);
            end
        end
    endtask

    task automatic test_overflow();
        logic [24:0] ea[$];
        logic [15:0] ed[$];
        logic [24:0] msize, a, e;
        logic [15:0] d;
        bit to;
        clear_obs();
        msize = '0;
        ack_en = 1'b0;
        start_dl(8'h01);
        for (int i = 0; i < 6; i++) begin
            a = 25'(32'h40 + 4 * i);
            d = 16'($urandom);
            // Ack withheld: one word in flight plus a full FIFO, the rest dropped.
            if (i < 1 + DEPTH) begin
                ea.push_back(BASE + a);
                ed.push_back(d);
                e = a + 25'd2;
                if (e > msize) msize = e;
            end
            send_word(8'h01, a, d, 1);
        end
        step(2);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag got=%b exp=1", overflow);
        end
        total++;
        if (mem_req !== 1'b1 || mem_addr !== ea[0] || mem_din !== ed[0]) begin
            bad++;
            $display("FAIL ovf_head got=%b/%h/%h exp=1/%h/%h", mem_req, mem_addr, mem_din,
                     ea[0], ed[0]);
        end
        step(12);
        ack_lat = 1;
        ack_en = 1'b1;
        end_and_wait(to);
        total++;
        if (to || got_addr.size() !== ea.size()) begin
            bad++;
            $display("FAIL ovf_count got=%0d exp=%0d timeout=%b", got_addr.size(), ea.size(), to);
        end
        for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== ea[i] || got_data[i] !== ed[i]) begin
                bad++;
                $display("FAIL ovf_word%0d got=%h/%h exp=%h/%h", i, got_addr[i], got_data[i],
                         ea[i], ed[i]);
            end
        end
        total++;
        if (done_size !== msize || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_size got=%h ovf=%b exp=%h ovf=1", done_size, overflow, msize);
        end
        start_dl(8'h01);
        total++;
        if (overflow !== 1'b0 || rom_size !== 25'd0 || load_busy !== 1'b1) begin
            bad++;
            $display("FAIL ovf_clear got=%b/%h/%b exp=0/0/1", overflow, rom_size, load_busy);
        end
        end_and_wait(to);
    endtask

    task automatic test_wrong_index();
        bit to;
        int d0, r0;
        clear_obs();
        d0 = done_cnt; r0 = req_cycles;
        start_dl(8'h02);
        for (int i = 0; i < 3; i++) send_word(8'h02, 25'(2 * i), 16'($urandom), 4);
        end_and_wait(to);
        total++;
        if (to || done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL idx_done got=%0d exp=1 timeout=%b", done_cnt - d0, to);
        end
        total++;
        if (req_cycles !== r0 || got_addr.size() !== 0 || done_size !== 25'd0) begin
            bad++;
            $display("FAIL idx_ignored got=%0d req/%0d wr/size=%h exp=0/0/0",
                     req_cycles - r0, got_addr.size(), done_size);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int r0, d0;
        clear_obs();
        ack_en = 1'b0;
        start_dl(8'h01);
        for (int i = 0; i < 3; i++) send_word(8'h01, 25'(32'h80 + 2 * i), 16'($urandom), 1);
        step(3);
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pending got=%b exp=1", mem_req);
        end
        reset = 1'b1;
        ioctl_download = 1'b0;
        step(1);
        total++;
        if (mem_req !== 1'b0 || load_busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_abandon got=%b/%b exp=0/0", mem_req, load_busy);
        end
        step(1);
        reset = 1'b0;
        r0 = req_cycles; d0 = done_cnt;
        ack_force = 1'b1;
        step(1);
        ack_force = 1'b0;
        step(4);
        total++;
        if (req_cycles !== r0 || got_addr.size() !== 0 || done_cnt !== d0) begin
            bad++;
            $display("FAIL rmid_late_ack got=%0d/%0d/%0d exp=0/0/0", req_cycles - r0,
                     got_addr.size(), done_cnt - d0);
        end
        // A fresh load must carry exactly its own word: nothing stale left behind.
        ack_en = 1'b1;
        ack_lat = 0;
        start_dl(8'h01);
        send_word(8'h01, 25'h20, 16'h5A5A, 4);
        end_and_wait(to);
        total++;
        if (to || got_addr.size() !== 1) begin
            bad++;
            $display("FAIL rmid_fresh_count got=%0d exp=1 timeout=%b", got_addr.size(), to);
        end else if (got_addr[0] !== BASE + 25'h20 || got_data[0] !== 16'h5A5A) begin
            bad++;
            $display("FAIL rmid_fresh_word got=%h/%h exp=%h/5a5a", got_addr[0], got_data[0],
                     BASE + 25'h20);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [15:0] d[4];
        clear_obs();
        ack_force = 1'b1;
        start_dl(8'h01);
        for (int i = 0; i < 4; i++) begin
            d[i] = 16'($urandom);
            send_word(8'h01, 25'(32'h100 + 2 * i), d[i], 1);
        end
        end_and_wait(to);
        ack_force = 1'b0;
        total++;
        if (to || got_addr.size() !== 4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got=%0d ovf=%b exp=4 ovf=0", got_addr.size(), overflow);
        end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== BASE + 25'(32'h100 + 2 * i) || got_data[i] !== d[i]) begin
                bad++;
                $display("FAIL b2b_word%0d got=%h/%h exp=%h/%h", i, got_addr[i], got_data[i],
                         BASE + 25'(32'h100 + 2 * i), d[i]);
            end
            if (i > 0) begin
                total++;
                if (got_t[i] - got_t[i-1] !== 2) begin
                    bad++;
                    $display("FAIL b2b_rate%0d got=%0d exp=2", i, got_t[i] - got_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_hdr_index();
        bit to;
        clear_obs();
        ack_lat = 0;
        start_dl(8'h81);
`ifdef IOCTL_HDR_SKIP_EN
        for (int i = 0; i < 256; i++) send_word(8'h81, 25'(2 * i), 16'($urandom), 1);
        send_word(8'h81, 25'd512, 16'hABCD, 4);
        end_and_wait(to);
        total++;
        if (to || got_addr.size() !== 1) begin
            bad++;
            $display("FAIL hdr_count got=%0d exp=1 timeout=%b", got_addr.size(), to);
        end else if (got_addr[0] !== BASE || got_data[0] !== 16'hABCD) begin
            bad++;
            $display("FAIL hdr_word got=%h/%h exp=%h/abcd", got_addr[0], got_data[0], BASE);
        end
        total++;
        if (done_size !== 25'd2) begin
            bad++;
            $display("FAIL hdr_size got=%h exp=2", done_size);
        end
`else
        for (int i = 0; i < 4; i++) send_word(8'h81, 25'(32'h200 + 2 * i), 16'($urandom), 4);
        end_and_wait(to);
        total++;
        if (to || got_addr.size() !== 0 || done_size !== 25'd0) begin
            bad++;
            $display("FAIL idx81_ignored got=%0d/%h exp=0/0 timeout=%b", got_addr.size(),
                     done_size, to);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_overflow();
        test_wrong_index();
        test_reset_mid();
        test_back_to_back();
        test_hdr_index();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
